// File: rtl/neo_pcb_pkg.sv
// Shared constants and packet layout for the Neo chip packet link.
package neo_pcb_pkg;

  localparam int GLOBAL_NEURON     = 2048;
  localparam int DEFAULT_BEAT_W    = 11;
  localparam int DEFAULT_NUM_BEATS = 2;
  localparam int DEFAULT_ADDR_W    = $clog2(GLOBAL_NEURON);
  localparam int DEFAULT_PKT_W     = DEFAULT_BEAT_W * DEFAULT_NUM_BEATS;

  typedef struct packed {
    logic [DEFAULT_PKT_W-DEFAULT_ADDR_W-1:0] hdr;
    logic [DEFAULT_ADDR_W-1:0]               addr;
  } neo_pkt_t;

endpackage

// File: rtl/neo_rx_fifo.sv
// Synchronous first-word-fall-through FIFO; head is valid on data_out whenever not empty.
module neo_rx_fifo #(
  parameter int WIDTH = 22,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] data_in,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] data_out
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign data_out = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // NOTE: storage has no reset; emptiness comes from the pointers and data_out is masked while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= data_in;
  end

endmodule

// File: rtl/neo_handshake_rx_stream.sv
// Neo 4-phase req/ack receiver: synchronise, assemble beats, subtract boundary offset,
// buffer in a FIFO and present packets on a valid/ready stream.
module neo_handshake_rx_stream
  import neo_pcb_pkg::*;
#(
  parameter int BEAT_W      = DEFAULT_BEAT_W,
  parameter int NUM_BEATS   = DEFAULT_NUM_BEATS,
  parameter int ADDR_W      = $clog2(GLOBAL_NEURON),
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 1024,
  parameter int CNT_W       = 16,
  localparam int PKT_W      = BEAT_W * NUM_BEATS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              boundary_w_en,
  input  logic [ADDR_W-1:0] chip_boundary_offset,
  input  logic              req_in,
  output logic              ack_out,
  input  logic [BEAT_W-1:0] rx_packet_in,
  output logic              pkt_valid,
  input  logic              pkt_ready,
  output logic [PKT_W-1:0]  pkt_data,
  input  logic              err_clr,
  output logic              overflow_flag,
  output logic              frame_err_flag,
  output logic [CNT_W-1:0]  drop_cnt,
  input  logic              chip_exe_valid,
  output logic              chip_exe_valid_synchronized
);

  localparam int BIDX_W = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam int TO_W   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [BIDX_W-1:0] LAST_BEAT = BIDX_W'(NUM_BEATS - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYC - 1);

  logic [SYNC_STAGES-1:0]             req_sync;
  logic [SYNC_STAGES-1:0]             exe_sync;
  logic                               req_s;
  logic                               req_s_d;
  logic                               rise;
  logic [BIDX_W-1:0]                  beat_idx;
  logic [NUM_BEATS-1:0][BEAT_W-1:0]   beats;
  logic [PKT_W-1:0]                   pkt_flat;
  logic                               pkt_done;
  logic [TO_W-1:0]                    to_cnt;
  logic                               timeout;
  logic [ADDR_W-1:0]                  offset;
  logic [PKT_W-1:0]                   corrected;
  logic [PKT_W-1:0]                   s_data;
  logic                               s_valid;
  logic                               s_drop;
  logic                               push_req;
  logic                               fifo_full;
  logic                               fifo_empty;
  logic                               pop;
  logic                               overflow_set;

  assign req_s   = req_sync[SYNC_STAGES-1];
  assign rise    = req_s & ~req_s_d;
  assign ack_out = req_s_d;
  assign chip_exe_valid_synchronized = exe_sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      req_sync <= '0;
      exe_sync <= '0;
      req_s_d  <= 1'b0;
    end else begin
      req_sync <= {req_sync[SYNC_STAGES-2:0], req_in};
      exe_sync <= {exe_sync[SYNC_STAGES-2:0], chip_exe_valid};
      req_s_d  <= req_s;
    end
  end

  assign timeout = ~rise && (beat_idx != '0) && (to_cnt == TO_LAST);

  // Beat index, completion strobe and inter-beat timeout; a beat arriving on the expiry cycle wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_idx       <= '0;
      pkt_done       <= 1'b0;
      to_cnt         <= '0;
      frame_err_flag <= 1'b0;
    end else begin
      pkt_done <= 1'b0;
      if (rise) begin
        to_cnt <= '0;
        if (beat_idx == LAST_BEAT) begin
          beat_idx <= '0;
          pkt_done <= 1'b1;
        end else begin
          beat_idx <= beat_idx + BIDX_W'(1);
        end
      end else if (timeout) begin
        beat_idx <= '0;
        to_cnt   <= '0;
      end else if (beat_idx != '0) begin
        to_cnt <= to_cnt + TO_W'(1);
      end else begin
        to_cnt <= '0;
      end

      if (timeout)      frame_err_flag <= 1'b1;
      else if (err_clr) frame_err_flag <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rise) beats[beat_idx] <= rx_packet_in;
  end

  always_ff @(posedge clk) begin
    if (rst)                offset <= '0;
    else if (boundary_w_en) offset <= chip_boundary_offset;
  end

  assign pkt_flat = beats;

  // NOTE: always_comb uses blocking assignments and assigns every output first to avoid a latch.
  always_comb begin
    corrected               = pkt_flat;
    corrected[ADDR_W-1:0]   = pkt_flat[ADDR_W-1:0] - offset;
  end

  // Stage S: address already corrected; the header bits never see a borrow.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_valid <= 1'b0;
      s_drop  <= 1'b0;
      s_data  <= '0;
    end else begin
      s_valid <= pkt_done;
      s_drop  <= (pkt_flat[ADDR_W-1:0] < offset);
      s_data  <= corrected;
    end
  end

  assign pop          = pkt_valid & pkt_ready;
  assign push_req     = s_valid & ~s_drop;
  assign overflow_set = push_req & fifo_full & ~pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt      <= '0;
      overflow_flag <= 1'b0;
    end else begin
      if (s_valid && s_drop && !(&drop_cnt)) drop_cnt <= drop_cnt + CNT_W'(1);
      if (overflow_set) overflow_flag <= 1'b1;
      else if (err_clr) overflow_flag <= 1'b0;
    end
  end

  neo_rx_fifo #(
    .WIDTH (PKT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push_req),
    .data_in  (s_data),
    .pop      (pop),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .data_out (pkt_data)
  );

  assign pkt_valid = ~fifo_empty;

endmodule

// File: tb/tb_neo_handshake_rx_stream.sv
// Directed bench for neo_handshake_rx_stream: default-parameter instance plus a
// 3-beat / 3-stage / 8-bit instance for the parameter sweep.
module tb_neo_handshake_rx_stream;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // Instance A: default parameters (PKT_W = 22, ADDR_W = 11)
  logic        a_wen = 1'b0;
  logic [10:0] a_off = '0;
  logic        a_req = 1'b0;
  logic        a_ack;
  logic [10:0] a_rx = '0;
  logic        a_valid;
  logic        a_ready = 1'b0;
  logic [21:0] a_data;
  logic        a_clr = 1'b0;
  logic        a_ovf;
  logic        a_ferr;
  logic [15:0] a_drop;
  logic        a_exe = 1'b0;
  logic        a_exe_s;

  // Instance B: NUM_BEATS=3, SYNC_STAGES=3, BEAT_W=8 (PKT_W = 24)
  logic        b_wen = 1'b0;
  logic [10:0] b_off = '0;
  logic        b_req = 1'b0;
  logic        b_ack;
  logic [7:0]  b_rx = '0;
  logic        b_valid;
  logic        b_ready = 1'b0;
  logic [23:0] b_data;
  logic        b_clr = 1'b0;
  logic        b_ovf;
  logic        b_ferr;
  logic [15:0] b_drop;
  logic        b_exe = 1'b0;
  logic        b_exe_s;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  neo_handshake_rx_stream dut_a (
    .clk (clk), .rst (rst),
    .boundary_w_en (a_wen), .chip_boundary_offset (a_off),
    .req_in (a_req), .ack_out (a_ack), .rx_packet_in (a_rx),
    .pkt_valid (a_valid), .pkt_ready (a_ready), .pkt_data (a_data),
    .err_clr (a_clr), .overflow_flag (a_ovf), .frame_err_flag (a_ferr),
    .drop_cnt (a_drop), .chip_exe_valid (a_exe),
    .chip_exe_valid_synchronized (a_exe_s)
  );

  neo_handshake_rx_stream #(
    .BEAT_W (8), .NUM_BEATS (3), .SYNC_STAGES (3)
  ) dut_b (
    .clk (clk), .rst (rst),
    .boundary_w_en (b_wen), .chip_boundary_offset (b_off),
    .req_in (b_req), .ack_out (b_ack), .rx_packet_in (b_rx),
    .pkt_valid (b_valid), .pkt_ready (b_ready), .pkt_data (b_data),
    .err_clr (b_clr), .overflow_flag (b_ovf), .frame_err_flag (b_ferr),
    .drop_cnt (b_drop), .chip_exe_valid (b_exe),
    .chip_exe_valid_synchronized (b_exe_s)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_a(input logic [10:0] d);
    int n;
    a_rx  = d;
    a_req = 1'b1;
    n = 0;
    while (a_ack !== 1'b1 && n < 40) begin tick(1); n++; end
    check("a_ack_rise", {31'd0, a_ack}, 32'd1);
    a_req = 1'b0;
    n = 0;
    while (a_ack !== 1'b0 && n < 40) begin tick(1); n++; end
    check("a_ack_fall", {31'd0, a_ack}, 32'd0);
  endtask

  task automatic send_b(input logic [7:0] d);
    int n;
    b_rx  = d;
    b_req = 1'b1;
    n = 0;
    while (b_ack !== 1'b1 && n < 40) begin tick(1); n++; end
    check("b_ack_rise", {31'd0, b_ack}, 32'd1);
    b_req = 1'b0;
    n = 0;
    while (b_ack !== 1'b0 && n < 40) begin tick(1); n++; end
    check("b_ack_fall", {31'd0, b_ack}, 32'd0);
  endtask

  initial begin
    // Reset values
    tick(2);
    check("rst_ack",   {31'd0, a_ack},   32'd0);
    check("rst_valid", {31'd0, a_valid}, 32'd0);
    check("rst_data",  {10'd0, a_data},  32'd0);
    check("rst_ovf",   {31'd0, a_ovf},   32'd0);
    check("rst_ferr",  {31'd0, a_ferr},  32'd0);
    check("rst_drop",  {16'd0, a_drop},  32'd0);
    check("rst_exe",   {31'd0, a_exe_s}, 32'd0);
    rst = 1'b0;

    // Status synchroniser: two stages
    a_exe = 1'b1;
    tick(1);
    check("exe_sync_1", {31'd0, a_exe_s}, 32'd0);
    tick(1);
    check("exe_sync_2", {31'd0, a_exe_s}, 32'd1);

    // Offset subtraction with exact latency and ack timing
    a_off = 11'h100; a_wen = 1'b1; tick(1); a_wen = 1'b0;
    send_a(11'h123);
    a_rx  = 11'h456;
    a_req = 1'b1;
    tick(2);
    check("lat_ack_e2", {31'd0, a_ack}, 32'd0);
    tick(1);
    check("lat_ack_e3", {31'd0, a_ack}, 32'd1);
    a_req = 1'b0;
    tick(1);
    check("lat_valid_e4", {31'd0, a_valid}, 32'd0);
    tick(1);
    check("lat_valid_e5", {31'd0, a_valid}, 32'd1);
    check("offset_data",  {10'd0, a_data},  32'h0022_B023);
    check("ack_hold_e5",  {31'd0, a_ack},   32'd1);
    tick(1);
    check("ack_fall_e6",  {31'd0, a_ack},   32'd0);
    a_ready = 1'b1; tick(1); a_ready = 1'b0;
    check("offset_drained", {31'd0, a_valid}, 32'd0);

    // Underflow drop, then exact-boundary address
    a_off = 11'h200; a_wen = 1'b1; tick(1); a_wen = 1'b0;
    send_a(11'h1FF); send_a(11'h00A);
    tick(1);
    check("uf_no_valid", {31'd0, a_valid}, 32'd0);
    check("uf_drop_cnt", {16'd0, a_drop},  32'd1);
    send_a(11'h200); send_a(11'h00B);
    check("uf_edge_valid", {31'd0, a_valid}, 32'd1);
    check("uf_edge_data",  {10'd0, a_data},  32'h0000_5800);
    a_ready = 1'b1; tick(1); a_ready = 1'b0;

    // Overflow: five packets into a four-entry FIFO with no consumer
    for (int i = 0; i < 5; i++) begin
      send_a(11'(11'h201 + i));
      send_a(11'(i + 1));
    end
    check("ovf_flag",  {31'd0, a_ovf},  32'd1);
    check("ovf_valid", {31'd0, a_valid}, 32'd1);
    check("ovf_drop",  {16'd0, a_drop},  32'd1);
    a_clr = 1'b1; tick(1); a_clr = 1'b0;
    check("ovf_clr", {31'd0, a_ovf}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("ovf_drain_%0d", i), {10'd0, a_data},
            32'(((i + 1) << 11) | (i + 1)));
      a_ready = 1'b1; tick(1); a_ready = 1'b0;
    end
    check("ovf_empty", {31'd0, a_valid}, 32'd0);

    // Timeout recovery
    send_a(11'h050);
    tick(1000);
    check("to_not_yet", {31'd0, a_ferr}, 32'd0);
    tick(60);
    check("to_expired", {31'd0, a_ferr}, 32'd1);
    send_a(11'h210); send_a(11'h003);
    check("to_recover_valid", {31'd0, a_valid}, 32'd1);
    check("to_recover_data",  {10'd0, a_data},  32'h0000_1810);
    a_ready = 1'b1; tick(1); a_ready = 1'b0;
    a_clr = 1'b1; tick(1); a_clr = 1'b0;
    check("to_clr", {31'd0, a_ferr}, 32'd0);

    // Reset between beats of a packet
    send_a(11'h077);
    rst = 1'b1;
    tick(1);
    check("mid_rst_ack",   {31'd0, a_ack},   32'd0);
    check("mid_rst_valid", {31'd0, a_valid}, 32'd0);
    check("mid_rst_drop",  {16'd0, a_drop},  32'd0);
    check("mid_rst_exe",   {31'd0, a_exe_s}, 32'd0);
    rst = 1'b0;
    send_a(11'h345); send_a(11'h012);
    check("post_rst_valid", {31'd0, a_valid}, 32'd1);
    check("post_rst_data",  {10'd0, a_data},  32'h0000_9345);
    a_ready = 1'b1; tick(1); a_ready = 1'b0;

    // Parameter sweep: 3 beats of 8 bits, 3 sync stages, latency 6 edges
    b_off = 11'h011; b_wen = 1'b1; tick(1); b_wen = 1'b0;
    send_b(8'h11); send_b(8'h22);
    b_rx  = 8'h33;
    b_req = 1'b1;
    tick(3);
    check("b_ack_e3", {31'd0, b_ack}, 32'd0);
    tick(1);
    check("b_ack_e4", {31'd0, b_ack}, 32'd1);
    b_req = 1'b0;
    tick(1);
    check("b_valid_e5", {31'd0, b_valid}, 32'd0);
    tick(1);
    check("b_valid_e6", {31'd0, b_valid}, 32'd1);
    check("b_data",     {8'd0, b_data},   32'h0033_2200);
    b_ready = 1'b1; tick(1); b_ready = 1'b0;
    check("b_drained",  {31'd0, b_valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
